// File: rtl/macc_pkg.sv
// Shared types and constants for the MACC sequencer: FSM encoding, the
// (-128,-128) product substitute and the result saturation limits.
package macc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

  localparam int unsigned OPND_W    = 8;
  localparam int unsigned MUL_W     = 15;
  localparam int unsigned PROD_W    = 16;
  localparam int unsigned OUT_W_DEF = 16;

  // The only operand pair whose product does not fit the multiplier's output
  localparam int signed NEG_SQ_PROD = 16384;

  localparam int signed SAT_MAX = (1 <<< (OUT_W_DEF - 1)) - 1;
  localparam int signed SAT_MIN = -(1 <<< (OUT_W_DEF - 1));

endpackage

// File: rtl/Mul.sv
// 8x8 signed radix-4 Booth multiplier, combinational, 15-bit product
// (the result is exact for every pair except -128 * -128).
module Mul
  import macc_pkg::*;
(
  input  logic signed [OPND_W-1:0] x,
  input  logic signed [OPND_W-1:0] y,
  output logic signed [MUL_W-1:0]  p
);

  logic signed [MUL_W-1:0] xs;
  logic signed [MUL_W-1:0] pp;
  logic signed [MUL_W-1:0] sum;
  logic [OPND_W:0]         yb;

  // Four Booth digits in {-2..2}, each selecting a shifted copy of x
  always_comb begin
    xs  = MUL_W'(x);
    yb  = {y, 1'b0};
    pp  = '0;
    sum = '0;
    for (int i = 0; i < 4; i++) begin
      unique case (yb[2*i +: 3])
        3'b001, 3'b010: pp = xs;
        3'b011:         pp = xs <<< 1;
        3'b100:         pp = -(xs <<< 1);
        3'b101, 3'b110: pp = -xs;
        default:        pp = '0;
      endcase
      sum = sum + (pp <<< (2 * i));
    end
    p = sum;
  end

endmodule

// File: rtl/macc_seq_ctrl.sv
// Dot-product sequencer around the Booth multiplier: operand handshake,
// product register, accumulator and result handshake. Define MACC_SAT_EN
// to saturate the result to OUT_W bits and expose out_sat.
module macc_seq_ctrl
  import macc_pkg::*;
#(
  parameter int unsigned LEN_W = 8,
  parameter int unsigned ACC_W = 24,
  parameter int unsigned OUT_W = OUT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [LEN_W-1:0]     cfg_len,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [OPND_W-1:0]    in_x,
  input  logic [OPND_W-1:0]    in_y,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_W-1:0]     out_acc,
  output logic                 busy
`ifdef MACC_SAT_EN
  ,
  output logic                 out_sat
`endif
);

  state_t                   state_q, state_n;
  logic                     accept;
  logic                     neg_sq;
  logic [LEN_W-1:0]         cnt_q;
  logic [LEN_W-1:0]         len_m1;
  logic                     first_q;
  logic                     p_v_q;
  logic signed [PROD_W-1:0] p_q;
  logic signed [MUL_W-1:0]  mul_p;
  logic signed [ACC_W-1:0]  acc_q, acc_n;
  logic [OUT_W-1:0]         res_n;
`ifdef MACC_SAT_EN
  logic                     sat_n;
`endif

  assign accept = in_valid & in_ready;
  assign len_m1 = cfg_len - LEN_W'(1);
  assign neg_sq = (in_x == 8'h80) && (in_y == 8'h80);

  Mul u_mul (
    .x (in_x),
    .y (in_y),
    .p (mul_p)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_n;
  end

  // Next-state logic
  always_comb begin
    state_n = state_q;
    unique case (state_q)
      ST_IDLE:  if (accept) state_n = (len_m1 == '0) ? ST_FLUSH : ST_RUN;
      ST_RUN:   if (accept && (cnt_q == LEN_W'(1))) state_n = ST_FLUSH;
      ST_FLUSH: state_n = ST_OUT;
      ST_OUT:   if (out_ready) state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  // Accumulate next value and the result it would present
  always_comb begin
    acc_n = acc_q;
    if (p_v_q) acc_n = (first_q ? '0 : acc_q) + ACC_W'(p_q);
`ifdef MACC_SAT_EN
    sat_n = 1'b0;
    res_n = acc_n[OUT_W-1:0];
    if (acc_n > ACC_W'(SAT_MAX)) begin
      res_n = OUT_W'(SAT_MAX);
      sat_n = 1'b1;
    end else if (acc_n < ACC_W'(SAT_MIN)) begin
      res_n = OUT_W'(SAT_MIN);
      sat_n = 1'b1;
    end
`else
    res_n = acc_n[OUT_W-1:0];
`endif
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      first_q   <= 1'b0;
      p_v_q     <= 1'b0;
      p_q       <= '0;
      acc_q     <= '0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_acc   <= '0;
`ifdef MACC_SAT_EN
      out_sat   <= 1'b0;
`endif
    end else begin
      in_ready  <= (state_n == ST_IDLE) || (state_n == ST_RUN);
      busy      <= (state_n != ST_IDLE);
      out_valid <= (state_n == ST_OUT);
      p_v_q     <= accept;
      acc_q     <= acc_n;
      if (accept) begin
        p_q   <= neg_sq ? PROD_W'(NEG_SQ_PROD) : PROD_W'(mul_p);
        cnt_q <= (state_q == ST_IDLE) ? len_m1 : cnt_q - LEN_W'(1);
      end
      if (accept && (state_q == ST_IDLE)) first_q <= 1'b1;
      else if (p_v_q)                     first_q <= 1'b0;
      // The final accumulation always lands on the FLUSH -> OUT edge
      if (state_q == ST_FLUSH) begin
        out_acc <= res_n;
`ifdef MACC_SAT_EN
        out_sat <= sat_n;
`endif
      end
    end
  end

endmodule

// File: tb/tb_macc_seq_ctrl.sv
// Self-checking bench for macc_seq_ctrl: directed jobs plus randomized jobs
// compared against a sum-of-products reference model.
module tb_macc_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  cfg_len;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_x;
  logic [7:0]  in_y;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_acc;
  logic        busy;
`ifdef MACC_SAT_EN
  logic        out_sat;
`endif

  int total = 0;
  int bad   = 0;
  int jx[$];
  int jy[$];
  int gq[$];

  always #5 clk = ~clk;

  macc_seq_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_len   (cfg_len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_y      (in_y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_acc   (out_acc),
    .busy      (busy)
`ifdef MACC_SAT_EN
    ,
    .out_sat   (out_sat)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  // Reference: exact dot product, then wrap or clamp to 16 bits
  function automatic logic [15:0] model_out(input longint s);
`ifdef MACC_SAT_EN
    if (s > 32767)  return 16'h7fff;
    if (s < -32768) return 16'h8000;
`endif
    return 16'(s);
  endfunction

  function automatic logic model_sat(input longint s);
    return (s > 32767) || (s < -32768);
  endfunction

  task automatic add(input int x, input int y, input int g);
    jx.push_back(x);
    jy.push_back(y);
    gq.push_back(g);
  endtask

  // Present one pair at a negedge and return at the negedge after its accept
  task automatic push(input int x, input int y);
    int n = 0;
    in_valid = 1'b1;
    in_x     = 8'(x);
    in_y     = 8'(y);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("push_timeout", 32'(n), 32'(0));
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Run the job held in jx/jy/gq, then check result, latency and handshake
  task automatic run_job(input string tag, input int hold);
    longint      s = 0;
    int          n;
    int          lat;
    logic [15:0] e;
    n       = jx.size();
    cfg_len = 8'(n);
    for (int i = 0; i < n; i++) begin
      if (gq[i] > 0) repeat (gq[i]) @(negedge clk);
      push(jx[i], jy[i]);
      if (i == 0) cfg_len = 8'($urandom);
      s += longint'(jx[i] * jy[i]);
    end
    e = model_out(s);
    chk({tag, "_flush_valid"}, 32'(out_valid), 32'(0));
    chk({tag, "_flush_ready"}, 32'(in_ready), 32'(0));
    lat = 0;
    while (!out_valid && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(1));
    chk({tag, "_acc"}, 32'($signed(out_acc)), 32'($signed(e)));
`ifdef MACC_SAT_EN
    chk({tag, "_sat"}, 32'(out_sat), 32'(model_sat(s)));
`endif
    in_valid = 1'b1;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk({tag, "_hold_valid"}, 32'(out_valid), 32'(1));
      chk({tag, "_hold_ready"}, 32'(in_ready), 32'(0));
      chk({tag, "_hold_acc"}, 32'($signed(out_acc)), 32'($signed(e)));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_idle_busy"}, 32'(busy), 32'(0));
    chk({tag, "_idle_valid"}, 32'(out_valid), 32'(0));
    chk({tag, "_idle_ready"}, 32'(in_ready), 32'(1));
    jx.delete();
    jy.delete();
    gq.delete();
  endtask

  initial begin
    int n;
    rst       = 1'b1;
    cfg_len   = 8'd0;
    in_valid  = 1'b0;
    in_x      = 8'd0;
    in_y      = 8'd0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'(1));
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_out_acc", 32'(out_acc), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
`ifdef MACC_SAT_EN
    chk("rst_out_sat", 32'(out_sat), 32'(0));
`endif
    rst = 1'b0;
    @(negedge clk);

    add(3, -5, 0);
    run_job("single", 0);

    add(1, 1, 0); add(2, 2, 0); add(-3, 3, 1); add(127, -128, 0);
    run_job("four_gap", 1);

    add(-128, -128, 0);
    run_job("neg_sq", 0);

    for (int i = 0; i < 4; i++) add(-128, -128, 0);
    run_job("neg_sq_x4", 0);

    add(100, 100, 0); add(50, 7, 0);
    run_job("backpressure", 5);

    // Abort a job part-way, then check nothing survives into the next one
    cfg_len = 8'd4;
    push(9, 9);
    push(-7, 11);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'(0));
    chk("abort_ready", 32'(in_ready), 32'(1));
    chk("abort_acc", 32'(out_acc), 32'(0));
    add(2, 2, 0);
    run_job("after_abort", 0);

    for (int j = 0; j < 8; j++) begin
      n = int'($urandom_range(1, 7));
      for (int i = 0; i < n; i++)
        add(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
            (i == 0) ? 0 : int'($urandom_range(0, 2)));
      run_job("rand", int'($urandom_range(0, 3)));
    end

    // cfg_len of 0 selects 256 pairs
    for (int i = 0; i < 256; i++)
      add(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128, 0);
    run_job("len256", 1);

    for (int i = 0; i < 256; i++) add(-128, -128, 0);
    run_job("len256_max", 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
